// File: rtl/load_store_unit.sv
// Load/store unit: accepts one lw/sw from execute and runs a req/ack handshake to data memory.
// Define LSU_MISALIGN_CHECK_EN to reject accesses whose req_addr[1:0] != 0 instead of ignoring those bits.
module load_store_unit #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 32,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              req_valid,
    output logic              req_ready,
    input  logic              req_write,
    input  logic [31:0]       req_addr,
    input  logic [DATA_W-1:0] req_wdata,
    input  logic [4:0]        req_rd,
    output logic              stall,
    output logic              rsp_valid,
    output logic [DATA_W-1:0] rsp_data,
    output logic [4:0]        rsp_rd,
    output logic              mem_req,
    output logic              mem_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic              mem_ack,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              err
);
    localparam int CNT_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;

    typedef enum logic [1:0] {IDLE, WAIT, RESP} state_t;

    state_t           state;
    state_t           state_next;
    logic [CNT_W-1:0] wait_cnt;
    logic             accept;
    logic             misalign;
    logic             timeout_hit;
    logic             err_next;
    logic             unused_addr;

`ifdef LSU_MISALIGN_CHECK_EN
    assign misalign = (req_addr[1:0] != 2'b00);
`else
    assign misalign = 1'b0;
`endif

    // Upper byte-address bits wrap away; the low two only matter for the misalignment check.
    assign unused_addr = ^{req_addr[31:ADDR_W+2], req_addr[1:0]};

    // An ack on the same edge as the timeout takes priority, so timeout is only consulted without ack.
    assign timeout_hit = (TIMEOUT != 0) && (wait_cnt == CNT_W'(TIMEOUT - 1));

    assign req_ready = (state == IDLE);
    assign stall     = (state != IDLE);
    assign mem_req   = (state == WAIT);
    assign rsp_valid = (state == RESP);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        accept     = 1'b0;
        err_next   = 1'b0;
        case (state)
            IDLE: begin
                if (req_valid) begin
                    accept = 1'b1;
                    if (misalign) begin
                        err_next   = 1'b1;
                        state_next = req_write ? IDLE : RESP;
                    end else begin
                        state_next = WAIT;
                    end
                end
            end
            WAIT: begin
                if (mem_ack) begin
                    state_next = mem_write ? IDLE : RESP;
                end else if (timeout_hit) begin
                    err_next   = 1'b1;
                    state_next = mem_write ? IDLE : RESP;
                end
            end
            RESP: state_next = IDLE;
            default: state_next = IDLE;
        endcase
    end

    // Request fields are captured once at acceptance so mem_* stay stable for the whole WAIT.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            mem_write <= 1'b0;
            mem_addr  <= '0;
            mem_wdata <= '0;
            rsp_data  <= '0;
            rsp_rd    <= '0;
            wait_cnt  <= '0;
            err       <= 1'b0;
        end else begin
            err <= err_next;
            if (accept) begin
                mem_write <= req_write;
                mem_addr  <= req_addr[ADDR_W+1:2];
                mem_wdata <= req_wdata;
                rsp_rd    <= req_rd;
                wait_cnt  <= '0;
                if (misalign) begin
                    rsp_data <= '0;
                end
            end else if (state == WAIT) begin
                if (mem_ack) begin
                    if (!mem_write) begin
                        rsp_data <= mem_rdata;
                    end
                end else if (timeout_hit) begin
                    rsp_data <= '0;
                end else if (TIMEOUT != 0) begin
                    wait_cnt <= wait_cnt + CNT_W'(1);
                end
            end
        end
    end
endmodule

// File: tb/tb_load_store_unit.sv
// Self-checking bench for load_store_unit: a transaction-level model expands each access into
// per-cycle expectations that one compare process checks; a few literal values pin the model.
module tb_load_store_unit;
    localparam int TIMEOUT_P = 15;

    logic        clk;
    logic        rst_n;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic [4:0]  req_rd;
    logic        stall;
    logic        rsp_valid;
    logic [31:0] rsp_data;
    logic [4:0]  rsp_rd;
    logic        mem_req;
    logic        mem_write;
    logic [7:0]  mem_addr;
    logic [31:0] mem_wdata;
    logic        mem_ack;
    logic [31:0] mem_rdata;
    logic        err;

    typedef struct packed {
        logic        stall;
        logic        ready;
        logic        memReq;
        logic        memWrite;
        logic [7:0]  memAddr;
        logic [31:0] memWdata;
        logic        rspValid;
        logic [31:0] rspData;
        logic [4:0]  rspRd;
        logic        err;
    } cycleExp_t;

    cycleExp_t expQ[$];
    cycleExp_t cmpExp;
    bit        compareOn;
    int        compared;
    int        mismatched;

    load_store_unit #(
        .ADDR_W (8),
        .DATA_W (32),
        .TIMEOUT(TIMEOUT_P)
    ) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .req_valid(req_valid),
        .req_ready(req_ready),
        .req_write(req_write),
        .req_addr (req_addr),
        .req_wdata(req_wdata),
        .req_rd   (req_rd),
        .stall    (stall),
        .rsp_valid(rsp_valid),
        .rsp_data (rsp_data),
        .rsp_rd   (rsp_rd),
        .mem_req  (mem_req),
        .mem_write(mem_write),
        .mem_addr (mem_addr),
        .mem_wdata(mem_wdata),
        .mem_ack  (mem_ack),
        .mem_rdata(mem_rdata),
        .err      (err)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h at %0t", name, actual, expected, $time);
        end
    endtask

    function automatic cycleExp_t idleExp();
        cycleExp_t e;
        e       = '0;
        e.ready = 1'b1;
        return e;
    endfunction

    // Each cycle, the oldest pending expectation (or plain idle) is checked just after the edge.
    always begin
        @(posedge clk);
        #1;
        if (compareOn) begin
            if (expQ.size() > 0) cmpExp = expQ.pop_front();
            else                 cmpExp = idleExp();
            checkOutput("stall", stall, cmpExp.stall);
            checkOutput("req_ready", req_ready, cmpExp.ready);
            checkOutput("mem_req", mem_req, cmpExp.memReq);
            checkOutput("rsp_valid", rsp_valid, cmpExp.rspValid);
            checkOutput("err", err, cmpExp.err);
            if (cmpExp.memReq) begin
                checkOutput("mem_write", mem_write, cmpExp.memWrite);
                checkOutput("mem_addr", mem_addr, cmpExp.memAddr);
                checkOutput("mem_wdata", mem_wdata, cmpExp.memWdata);
            end
            if (cmpExp.rspValid) begin
                checkOutput("rsp_data", rsp_data, cmpExp.rspData);
                checkOutput("rsp_rd", rsp_rd, cmpExp.rspRd);
            end
        end
    end

    // ackDelay = WAIT cycles without ack before the ack edge; ackDelay >= TIMEOUT_P means never ack.
    task automatic applyStimulus(input bit wr, input logic [31:0] addr, input logic [31:0] wdata,
                                 input logic [4:0] rd, input int ackDelay, input logic [31:0] rdata,
                                 input logic [7:0] litAddr, input logic [31:0] litRsp);
        cycleExp_t e;
        bit        mis;
        bit        timedOut;
        int        waitCycles;
        mis = 1'b0;
`ifdef LSU_MISALIGN_CHECK_EN
        mis = (addr[1:0] != 2'b00);
`endif
        timedOut   = !mis && (ackDelay >= TIMEOUT_P);
        waitCycles = mis ? 0 : (timedOut ? TIMEOUT_P : ackDelay + 1);

        @(negedge clk);
        e          = idleExp();
        e.stall    = 1'b1;
        e.ready    = 1'b0;
        e.memReq   = 1'b1;
        e.memWrite = wr;
        e.memAddr  = 8'((addr >> 2) & 32'hFF);
        e.memWdata = wdata;
        for (int i = 0; i < waitCycles; i++) expQ.push_back(e);
        if (!wr) begin
            e          = idleExp();
            e.stall    = 1'b1;
            e.ready    = 1'b0;
            e.rspValid = 1'b1;
            e.rspData  = (timedOut || mis) ? 32'h0 : rdata;
            e.rspRd    = rd;
            e.err      = timedOut || mis;
            expQ.push_back(e);
        end else if (timedOut || mis) begin
            e     = idleExp();
            e.err = 1'b1;
            expQ.push_back(e);
        end

        req_valid = 1'b1;
        req_write = wr;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        @(negedge clk);
        req_valid = 1'b0;
        req_write = !wr;
        req_addr  = ~addr;
        req_wdata = ~wdata;
        req_rd    = ~rd;

        if (!mis) begin
            checkOutput("litMemAddr", mem_addr, litAddr);
            if (!timedOut) begin
                repeat (ackDelay) @(negedge clk);
                mem_ack   = 1'b1;
                mem_rdata = rdata;
                @(negedge clk);
                mem_ack   = 1'b0;
                mem_rdata = ~rdata;
            end else begin
                repeat (TIMEOUT_P) @(negedge clk);
            end
        end
        if (!wr) begin
            checkOutput("litRspValid", rsp_valid, 1);
            checkOutput("litRspData", rsp_data, litRsp);
        end

        for (int g = 0; g < 40 && expQ.size() != 0; g++) @(negedge clk);
        checkOutput("queueDrained", expQ.size(), 0);
        @(negedge clk);
    endtask

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        compared   = 0;
        mismatched = 0;
        compareOn  = 1'b0;
        rst_n      = 1'b0;
        req_valid  = 1'b0;
        req_write  = 1'b0;
        req_addr   = '0;
        req_wdata  = '0;
        req_rd     = '0;
        mem_ack    = 1'b0;
        mem_rdata  = '0;

        #12;
        checkOutput("rstReady", req_ready, 1);
        checkOutput("rstStall", stall, 0);
        checkOutput("rstMemReq", mem_req, 0);
        checkOutput("rstRspValid", rsp_valid, 0);
        checkOutput("rstErr", err, 0);
        checkOutput("rstMemAddr", mem_addr, 0);
        checkOutput("rstRspData", rsp_data, 0);
        @(negedge clk);
        rst_n     = 1'b1;
        compareOn = 1'b1;

        applyStimulus(1'b0, 32'h0000_0010, 32'h0, 5'd5, 0, 32'hDEAD_BEEF, 8'h04, 32'hDEAD_BEEF);
        applyStimulus(1'b1, 32'h0000_03FC, 32'h1234_5678, 5'd0, 3, 32'h0, 8'hFF, 32'h0);
        applyStimulus(1'b0, 32'h0000_0044, 32'h0, 5'd0, 1, 32'hCAFE_F00D, 8'h11, 32'hCAFE_F00D);
        applyStimulus(1'b0, 32'h0000_0080, 32'h0, 5'd7, 100, 32'h1111_1111, 8'h20, 32'h0);
        applyStimulus(1'b1, 32'h0000_0084, 32'hAAAA_5555, 5'd0, 100, 32'h0, 8'h21, 32'h0);
        applyStimulus(1'b0, 32'h0000_0400, 32'h0, 5'd3, 2, 32'hA5A5_0F0F, 8'h00, 32'hA5A5_0F0F);
        applyStimulus(1'b0, 32'h0000_0100, 32'h0, 5'd12, TIMEOUT_P - 1, 32'h0BAD_CAFE, 8'h40, 32'h0BAD_CAFE);
        applyStimulus(1'b0, 32'h0000_0013, 32'h0, 5'd9, 0, 32'h7777_8888, 8'h04, 32'h7777_8888);
        applyStimulus(1'b1, 32'h0000_0002, 32'h9999_0000, 5'd0, 1, 32'h0, 8'h00, 32'h0);

        mem_ack   = 1'b1;
        mem_rdata = 32'h5555_5555;
        @(negedge clk);
        mem_ack = 1'b0;
        repeat (2) @(negedge clk);

        compareOn = 1'b0;
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b0;
        req_addr  = 32'h0000_0020;
        req_rd    = 5'd4;
        @(negedge clk);
        req_valid = 1'b0;
        checkOutput("preRstMemReq", mem_req, 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("midRstMemReq", mem_req, 0);
        checkOutput("midRstStall", stall, 0);
        checkOutput("midRstReady", req_ready, 1);
        checkOutput("midRstRspValid", rsp_valid, 0);
        checkOutput("midRstMemAddr", mem_addr, 0);
        #1 rst_n = 1'b1;
        @(negedge clk);
        compareOn = 1'b1;
        repeat (3) @(negedge clk);

        applyStimulus(1'b0, 32'h0000_0024, 32'h0, 5'd6, 0, 32'h0123_4567, 8'h09, 32'h0123_4567);

        compareOn = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end
endmodule

// File: doc/load_store_unit.md
Name: load_store_unit

Overview:
Initiator-side memory access stage for the pipelined MIPS core.
- Accepts one load or store per handshake from the execute stage.
- Converts the byte address to a word address and drives a req/ack handshake toward the data memory.
- Stalls the pipeline while a transaction is in flight.
- Returns load data to writeback.

Parameters:
ADDR_W, 8, memory word-address width (256 x 32-bit memory)
DATA_W, 32, data word width
TIMEOUT, 15, max cycles waiting for mem_ack before abort; 0 disables the timeout

Ports:
clk  in  1  system clock, all state on posedge
rst_n  in  1  asynchronous active-low reset
req_valid  in  1  pipeline presents a load/store
req_ready  out  1  unit can accept a request (IDLE only)
req_write  in  1  1 = store (sw), 0 = load (lw)
req_addr  in  32  byte address from ALU
req_wdata  in  DATA_W  store data
req_rd  in  5  load destination register
stall  out  1  high whenever state != IDLE
rsp_valid  out  1  one-cycle load result strobe to writeback
rsp_data  out  DATA_W  load data
rsp_rd  out  5  destination register of the returned load
mem_req  out  1  memory request, held until acknowledged
mem_write  out  1  request is a write
mem_addr  out  ADDR_W  word address, req_addr[ADDR_W+1:2]
mem_wdata  out  DATA_W  write data
mem_ack  in  1  memory completes the access this cycle
mem_rdata  in  DATA_W  read data, valid with mem_ack on loads
err  out  1  one-cycle pulse on timeout (or misalignment, see option)

Behaviour:
- Reset (async, rst_n=0):
  - State goes to IDLE. The wait counter clears.
  - mem_req, mem_write, rsp_valid, err, stall are 0. mem_addr, mem_wdata, rsp_data, rsp_rd are 0.
  - req_ready is 1.
  - Reset mid-transaction drops mem_req immediately. The in-flight access is abandoned and no response is issued.
- States: IDLE, WAIT, RESP.
- IDLE:
  - req_ready=1.
  - On a posedge with req_valid=1, the unit registers write/addr/wdata/rd and drives mem_req=1.
  - Next state is WAIT and the counter clears.
- WAIT:
  - mem_req=1 and the mem_* outputs are stable.
  - On a posedge with mem_ack=1:
    - Load: capture mem_rdata into rsp_data, then go to RESP.
    - Store: go to IDLE. No rsp_valid is produced.
  - mem_req deasserts in the cycle after the ack.
- RESP: rsp_valid=1 for exactly one cycle with rsp_data/rsp_rd, then IDLE. req_ready=0 in RESP, so there is no same-cycle accept.
- Latency:
  - Acceptance at edge N with mem_ack high at edge N+1 gives load rsp_valid during N+1..N+2 and req_ready high again after N+2.
  - A store returns to IDLE at N+1.
- Timeout:
  - The counter increments on each WAIT cycle without an ack.
  - When the count reaches TIMEOUT, the unit aborts:
    - Load: go to RESP with rsp_data=0 and err=1 in the RESP cycle.
    - Store: pulse err for one cycle while returning to IDLE.
  - An ack arriving in the same edge as the timeout wins; there is no err.
- mem_ack sampled in IDLE or RESP is ignored.
- Loads with req_rd=0 still access memory and respond with rsp_rd=0. Writeback discards the result.
- Address bits above ADDR_W+1 are ignored, so accesses wrap modulo 2^ADDR_W words.
- stall = (state != IDLE), combinational from registered state.

Optional Feature:
LSU_MISALIGN_CHECK_EN
- Defined:
  - When req_addr[1:0] != 0 at acceptance, the unit issues no mem_req.
  - Load: go directly to RESP with rsp_data=0 and err=1.
  - Store: err pulses for one cycle and the unit stays in IDLE (req_ready stays 1). Memory is never written.
- Undefined: req_addr[1:0] are silently ignored and the access goes to the containing word.

Test Plan:
- Reset then load: req addr=0x0000_0010, rd=5, mem_ack one cycle after mem_req, mem_rdata=0xDEAD_BEEF -> mem_addr=4, rsp_valid one cycle later with rsp_data=0xDEAD_BEEF, rsp_rd=5, stall high for 2 cycles.
- Store addr=0x0000_03FC, wdata=0x1234_5678, ack delayed 3 cycles -> mem_req/mem_write/mem_addr=0xFF/mem_wdata held 4 cycles, no rsp_valid, req_ready returns 1 the cycle after the ack.
- Load with no mem_ack, TIMEOUT=15 -> mem_req drops after 15 WAIT cycles, rsp_valid=1, rsp_data=0, err=1 for one cycle.
- Address wrap: load addr=0x0000_0400 -> mem_addr=0x00.
- rst_n pulsed low during WAIT -> mem_req and stall fall without a clock edge, no rsp_valid afterward, the next request is accepted normally.
- With LSU_MISALIGN_CHECK_EN, store addr=0x0000_0002 -> mem_req never asserted, err pulses once, req_ready stays 1.
